// File: rtl/matrix_block_scheduler.sv
// matrix_block_scheduler
// Sequences the shared 2x2-block MAC unit for the 4x4 matrix datapaths.
// Each pass walks output blocks C[i][j] in row-major order; for every block it
// issues k=0 (accumulator clear) then k=1 sub-operations, then strobes a
// write-back. After iter_count passes, done is held for OUT_HOLD cycles.
//
// Build option: define MATRIX_SCHED_TIMEOUT_EN to abort a WAIT that sees no
// res_valid within TIMEOUT cycles (sets sticky err, skips write-back, goes to
// HOLD). Without it WAIT lasts indefinitely and err stays 0.
module matrix_block_scheduler #(
   parameter int ITER_W   = 8,
   parameter int OUT_HOLD = 10,
   parameter int TIMEOUT  = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ITER_W-1:0] iter_count,
   output logic              op_valid,
   input  logic              op_ready,
   output logic              op_i,
   output logic              op_j,
   output logic              op_k,
   output logic              op_clr_acc,
   input  logic              res_valid,
   output logic              wb_en,
   output logic              wb_i,
   output logic              wb_j,
   output logic [ITER_W-1:0] pass_left,
   output logic              busy,
   output logic              done,
   output logic              err
);

`ifdef MATRIX_SCHED_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_NEXT  = 3'd4;
   localparam logic [2:0] S_HOLD  = 3'd5;

   logic [2:0]        state;
   logic              i_q;
   logic              j_q;
   logic              k_q;
   logic [ITER_W-1:0] pass_q;
   logic [7:0]        hold_cnt;
   logic [TW-1:0]     wait_cnt;
   logic              err_q;

   // Control FSM with block indices, pass counter, hold and wait counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         i_q      <= 1'b0;
         j_q      <= 1'b0;
         k_q      <= 1'b0;
         pass_q   <= '0;
         hold_cnt <= '0;
         wait_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  pass_q   <= iter_count;
                  i_q      <= 1'b0;
                  j_q      <= 1'b0;
                  k_q      <= 1'b0;
                  err_q    <= 1'b0;
                  hold_cnt <= '0;
                  state    <= (iter_count != '0) ? S_ISSUE : S_HOLD;
               end
            end
            S_ISSUE: begin
               // indices stay put until the unit takes the request
               if (op_ready) begin
                  wait_cnt <= '0;
                  state    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (res_valid) begin
                  if (!k_q) begin
                     k_q   <= 1'b1;
                     state <= S_ISSUE;
                  end else begin
                     state <= S_WRITE;
                  end
               end else if (TO_EN && (wait_cnt == TW'(TIMEOUT - 1))) begin
                  // abandon the outstanding op; no write-back for this block
                  err_q    <= 1'b1;
                  k_q      <= 1'b0;
                  hold_cnt <= '0;
                  state    <= S_HOLD;
               end else begin
                  wait_cnt <= wait_cnt + TW'(1);
               end
            end
            S_WRITE: begin
               k_q <= 1'b0;
               if (i_q && j_q) begin
                  state <= S_NEXT;
               end else begin
                  if (j_q) begin
                     j_q <= 1'b0;
                     i_q <= 1'b1;
                  end else begin
                     j_q <= 1'b1;
                  end
                  state <= S_ISSUE;
               end
            end
            S_NEXT: begin
               i_q <= 1'b0;
               j_q <= 1'b0;
               if (pass_q != '0) begin
                  pass_q <= pass_q - ITER_W'(1);
               end
               if (pass_q <= ITER_W'(1)) begin
                  hold_cnt <= '0;
                  state    <= S_HOLD;
               end else begin
                  state <= S_ISSUE;
               end
            end
            S_HOLD: begin
               // start is deliberately not looked at here
               if (hold_cnt == 8'(OUT_HOLD - 1)) begin
                  hold_cnt <= '0;
                  state    <= S_IDLE;
               end else begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Outputs decoded from state; indices come straight from the counters
   always_comb begin
      op_valid   = (state == S_ISSUE);
      op_i       = i_q;
      op_j       = j_q;
      op_k       = k_q;
      op_clr_acc = (state == S_ISSUE) && !k_q;
      wb_en      = (state == S_WRITE);
      wb_i       = i_q;
      wb_j       = j_q;
      pass_left  = pass_q;
      busy       = (state != S_IDLE);
      done       = (state == S_HOLD);
      err        = TO_EN ? err_q : 1'b0;
   end

endmodule

// File: tb/tb_matrix_block_scheduler.sv
// tb_matrix_block_scheduler
// Directed and randomized runs of matrix_block_scheduler. A transaction-level
// reference derives the expected op stream, write-backs, pass_left and timing
// directly from the pass/block/k ordering and handshake rules.
module tb_matrix_block_scheduler;
   localparam int ITER_W   = 8;
   localparam int OUT_HOLD = 10;
   localparam int TIMEOUT  = 64;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ITER_W-1:0] iter_count;
   logic              op_valid;
   logic              op_ready;
   logic              op_i;
   logic              op_j;
   logic              op_k;
   logic              op_clr_acc;
   logic              res_valid;
   logic              wb_en;
   logic              wb_i;
   logic              wb_j;
   logic [ITER_W-1:0] pass_left;
   logic              busy;
   logic              done;
   logic              err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   matrix_block_scheduler #(
      .ITER_W(ITER_W), .OUT_HOLD(OUT_HOLD), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .iter_count(iter_count),
      .op_valid(op_valid), .op_ready(op_ready), .op_i(op_i), .op_j(op_j),
      .op_k(op_k), .op_clr_acc(op_clr_acc), .res_valid(res_valid),
      .wb_en(wb_en), .wb_i(wb_i), .wb_j(wb_j), .pass_left(pass_left),
      .busy(busy), .done(done), .err(err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] all_outs();
      return {20'd0, op_valid, op_i, op_j, op_k, op_clr_acc, wb_en, wb_i, wb_j,
              busy, done, err, 1'b0} | {24'd0, pass_left};
   endfunction

   // One run of n passes. rdy_pct/res_pct: percent chance op_ready/res_valid
   // are high each cycle. stall: hold op_ready low (with res_valid high) for
   // the first 5 cycles. timed: check done latency = 21n+1 edges.
   task automatic run(input int n, input int rdy_pct, input int res_pct,
                      input bit stall, input bit timed, input string tag);
      int op_idx, wb_idx, edges, done_len, blk, k;
      bit waiting, prev_hs, prev_res, exp_wb, seen_done;
      op_idx = 0; wb_idx = 0; waiting = 0; prev_hs = 0; prev_res = 0;
      seen_done = 0;
      iter_count = ITER_W'(n);
      start = 1'b1; op_ready = 1'b1; res_valid = 1'b0;
      tick();
      edges = 1;
      start = 1'b0;
      iter_count = ITER_W'($urandom);
      for (int cyc = 0; cyc < 4000; cyc++) begin
         exp_wb = 1'b0;
         if (prev_hs) begin
            waiting = 1'b1;
         end else if (waiting && prev_res) begin
            waiting = 1'b0;
            exp_wb  = ((op_idx - 1) % 2 == 1);
         end
         chk({tag, ".wb_en"}, wb_en, exp_wb);
         if (wb_en) begin
            blk = wb_idx % 4;
            chk({tag, ".wb_i"}, wb_i, blk / 2);
            chk({tag, ".wb_j"}, wb_j, blk % 2);
            wb_idx++;
         end
         if (waiting) chk({tag, ".op_valid_in_wait"}, op_valid, 0);
         if (op_valid) begin
            blk = (op_idx / 2) % 4;
            k   = op_idx % 2;
            chk({tag, ".op_i"}, op_i, blk / 2);
            chk({tag, ".op_j"}, op_j, blk % 2);
            chk({tag, ".op_k"}, op_k, k);
            chk({tag, ".op_clr_acc"}, op_clr_acc, (k == 0));
            chk({tag, ".pass_left"}, pass_left, n - op_idx / 8);
         end
         if (done) begin
            seen_done = 1'b1;
            break;
         end
         if (stall && cyc < 5) begin
            op_ready  = 1'b0;
            res_valid = 1'b1;
         end else begin
            op_ready  = ($urandom_range(99) < rdy_pct);
            res_valid = ($urandom_range(99) < res_pct);
         end
         start    = ($urandom_range(7) == 0);
         prev_hs  = op_valid && op_ready;
         prev_res = res_valid;
         if (prev_hs) op_idx++;
         tick();
         edges++;
      end
      start = 1'b0;
      if (!seen_done) begin
         chk({tag, ".done_seen"}, 0, 1);
      end else begin
         if (timed) chk({tag, ".done_latency"}, edges, 21 * n + 1);
         chk({tag, ".ops_total"}, op_idx, 8 * n);
         chk({tag, ".wb_total"}, wb_idx, 4 * n);
         chk({tag, ".pass_left_end"}, pass_left, 0);
         chk({tag, ".err"}, err, 0);
         chk({tag, ".busy_hold"}, busy, 1);
         done_len = 0;
         for (int cyc = 0; cyc < 300 && done; cyc++) begin
            done_len++;
            start      = (cyc == 2);
            iter_count = 1;
            op_ready   = 1'b1;
            res_valid  = 1'b0;
            tick();
         end
         start = 1'b0;
         chk({tag, ".done_len"}, done_len, OUT_HOLD);
         chk({tag, ".busy_after"}, busy, 0);
         tick();
         chk({tag, ".hold_start_ignored"}, busy, 0);
      end
   endtask

   initial begin
      int wcnt;
      rst = 1'b1; start = 1'b0; iter_count = '0; op_ready = 1'b0; res_valid = 1'b0;
      tick();
      tick();
      chk("reset.outs", all_outs(), 0);
      rst = 1'b0;
      tick();
      chk("reset.idle_outs", all_outs(), 0);

      // directed runs with op_ready and res_valid always high
      run(1, 100, 100, 1'b0, 1'b1, "iter1");
      run(3, 100, 100, 1'b0, 1'b1, "iter3");
      run(0, 100, 100, 1'b0, 1'b1, "iter0");
      run(1, 100, 100, 1'b1, 1'b0, "stall");

      // randomized handshakes
      for (int r = 0; r < 5; r++) begin
         run($urandom_range(1, 3), 55, 40, 1'b0, 1'b0, "rand");
      end

      // reset during the WAIT of the second pass
      iter_count = 2; start = 1'b1; op_ready = 1'b1; res_valid = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 100 && !(op_valid && pass_left == 1); c++) tick();
      res_valid = 1'b0;
      tick();
      chk("rstmid.in_wait", {busy, op_valid, pass_left}, {1'b1, 1'b0, 8'd1});
      #2 rst = 1'b1;
      #1;
      chk("rstmid.async_outs", all_outs(), 0);
      tick();
      chk("rstmid.outs", all_outs(), 0);
      rst = 1'b0;
      res_valid = 1'b1;
      tick();
      chk("rstmid.stays_idle", all_outs(), 0);
      run(1, 100, 100, 1'b0, 1'b1, "after_rst");

`ifdef MATRIX_SCHED_TIMEOUT_EN
      // withheld result: abort after TIMEOUT WAIT cycles
      iter_count = 1; start = 1'b1; op_ready = 1'b1; res_valid = 1'b0;
      tick();
      start = 1'b0;
      tick();
      wcnt = 0;
      for (int c = 0; c < 300 && !done; c++) begin
         if (busy && !op_valid) wcnt++;
         chk("timeout.no_wb", wb_en, 0);
         tick();
      end
      chk("timeout.wait_cycles", wcnt, TIMEOUT);
      chk("timeout.err", err, 1);
      chk("timeout.done", done, 1);
      for (int c = 0; c < 300 && done; c++) tick();
      chk("timeout.err_sticky", err, 1);
      iter_count = 0; start = 1'b1;
      tick();
      start = 1'b0;
      chk("timeout.err_clear", err, 0);
      for (int c = 0; c < 300 && busy; c++) tick();
`else
      // withheld result: WAIT holds indefinitely, err never set
      iter_count = 1; start = 1'b1; op_ready = 1'b1; res_valid = 1'b0;
      tick();
      start = 1'b0;
      wcnt = 0;
      for (int c = 0; c < 150; c++) begin
         if (wb_en || done || err) wcnt++;
         tick();
      end
      chk("nowait_to.events", wcnt, 0);
      chk("nowait_to.busy", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      chk("nowait_to.recovered", all_outs(), 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
